// File: rtl/wb_merge.sv
// wb_merge: merges the in-order W-stage write stream with out-of-order
// mult/div results onto the single GRF write port. It also keeps a
// per-register busy scoreboard so decode can stall on pending results.
module wb_merge #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    input  logic [4:0]  q_addr3,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        q_busy3,
    output logic [4:0]  RegWrite,
    output logic        WriteEn,
    output logic [31:0] WData,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Result FIFO storage. Only the pointers are reset; stale entries are
    // unreachable once the pointers are equal.
    logic [4:0]  fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [AW:0] wptr, rptr;

    logic [31:0] busy, busy_nxt;
    logic        full, empty, pipe_hit, push, pop, err_nxt;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty     = (wptr == rptr);
    assign md_ready  = !full;
    assign head_addr = fifo_addr[rptr[AW-1:0]];
    assign head_data = fifo_data[rptr[AW-1:0]];

    // Queries see the registered scoreboard only.
    assign q_busy1 = busy[q_addr1];
    assign q_busy2 = busy[q_addr2];
    assign q_busy3 = busy[q_addr3];

    // Port arbitration: pipe writes to $0 neither write nor block a pop;
    // results to $0 are accepted and discarded.
    always_comb begin
        pipe_hit = pipe_we && (pipe_addr != 5'd0);
        pop      = !empty && !pipe_hit;
        push     = md_valid && md_ready && (md_addr != 5'd0);
    end

    // Scoreboard next state: clear on pop, then set on issue so set wins.
    always_comb begin
        busy_nxt = busy;
        if (pop)
            busy_nxt[head_addr] = 1'b0;
        if (iss_valid && (iss_addr != 5'd0))
            busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Contract checks, all against the registered scoreboard.
    always_comb begin
        err_nxt = 1'b0;
        if (pipe_we && busy[pipe_addr])
            err_nxt = 1'b1;
        if (iss_valid && busy[iss_addr])
            err_nxt = 1'b1;
        if (md_valid && (md_addr != 5'd0) && !busy[md_addr])
            err_nxt = 1'b1;
    end

    // FIFO entry write; data storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr[AW-1:0]] <= md_addr;
            fifo_data[wptr[AW-1:0]] <= md_data;
        end
    end

    // FIFO pointers, scoreboard and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            busy <= '0;
            err  <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
            busy <= busy_nxt;
            if (err_nxt)
                err <= 1'b1;
        end
    end

    // GRF write-port register: pipe first, then FIFO head, else idle with
    // address/data held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite <= 5'd0;
            WriteEn  <= 1'b0;
            WData    <= 32'd0;
        end else if (pipe_hit) begin
            RegWrite <= pipe_addr;
            WriteEn  <= 1'b1;
            WData    <= pipe_data;
        end else if (pop) begin
            RegWrite <= head_addr;
            WriteEn  <= 1'b1;
            WData    <= head_data;
        end else begin
            WriteEn  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: pipe passthrough, mult/div round trip,
// priority/starvation, full and pointer wrap, contracts, async reset.
module tb_wb_merge;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  q_addr1, q_addr2, q_addr3;
    logic        q_busy1, q_busy2, q_busy3;
    logic [4:0]  RegWrite;
    logic        WriteEn;
    logic [31:0] WData;
    logic        err;

    int vecs = 0;
    int errs = 0;

    wb_merge #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
        .md_ready(md_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_addr3(q_addr3),
        .q_busy1(q_busy1), .q_busy2(q_busy2), .q_busy3(q_busy3),
        .RegWrite(RegWrite), .WriteEn(WriteEn), .WData(WData), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we = 0; pipe_addr = 0; pipe_data = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        iss_valid = 0; iss_addr = 0;
    endtask

    task automatic pulse_reset();
        reset = 0;
        #3;
        reset = 1;
    endtask

    initial begin
        idle();
        q_addr1 = 0; q_addr2 = 0; q_addr3 = 0;
        reset = 0;
        #2;
        check("rst_we",    32'(WriteEn), 0);
        check("rst_addr",  32'(RegWrite), 0);
        check("rst_data",  WData, 0);
        check("rst_ready", 32'(md_ready), 1);
        check("rst_err",   32'(err), 0);
        tick();
        reset = 1;

        // Pipe passthrough, then a $0 write that must not assert WriteEn.
        pipe_we = 1; pipe_addr = 5; pipe_data = 32'h1234;
        tick();
        check("pipe_we",   32'(WriteEn), 1);
        check("pipe_addr", 32'(RegWrite), 5);
        check("pipe_data", WData, 32'h1234);
        pipe_addr = 0; pipe_data = 32'h55;
        tick();
        check("pipe0_we",   32'(WriteEn), 0);
        check("pipe0_hold", WData, 32'h1234);
        check("pipe0_addr", 32'(RegWrite), 5);
        idle();

        // Mult/div round trip on $8.
        q_addr1 = 8;
        iss_valid = 1; iss_addr = 8;
        #1;
        check("iss_same_cycle", 32'(q_busy1), 0);
        tick();
        check("busy8_set", 32'(q_busy1), 1);
        idle();
        md_valid = 1; md_addr = 8; md_data = 32'hDEADBEEF;
        tick();
        idle();
        check("md_n1_we",   32'(WriteEn), 0);
        check("md_n1_busy", 32'(q_busy1), 1);
        tick();
        check("md_we",   32'(WriteEn), 1);
        check("md_addr", 32'(RegWrite), 8);
        check("md_data", WData, 32'hDEADBEEF);
        check("md_busy_clr", 32'(q_busy1), 0);
        check("md_err", 32'(err), 0);

        // Priority: queued $9 starved by three pipe writes to $3.
        q_addr2 = 9;
        iss_valid = 1; iss_addr = 9;
        tick();
        idle();
        md_valid = 1; md_addr = 9; md_data = 32'hA;
        tick();
        idle();
        for (int i = 1; i <= 3; i++) begin
            pipe_we = 1; pipe_addr = 3; pipe_data = 32'h30 + i;
            tick();
            check("prio_addr", 32'(RegWrite), 3);
            check("prio_data", WData, 32'h30 + i);
            check("prio_busy9", 32'(q_busy2), 1);
        end
        idle();
        tick();
        check("prio_md_addr", 32'(RegWrite), 9);
        check("prio_md_data", WData, 32'hA);
        check("prio_busy9_clr", 32'(q_busy2), 0);
        tick();
        check("prio_idle_we", 32'(WriteEn), 0);

        // Full and pointer wrap, five rounds of two results.
        for (int i = 0; i < 5; i++) begin
            iss_valid = 1; iss_addr = 10;
            tick();
            iss_addr = 11;
            tick();
            idle();
            pipe_we = 1; pipe_addr = 3; pipe_data = 32'h3;
            md_valid = 1; md_addr = 10; md_data = 32'h100 + i;
            tick();
            check("wrap_ready1", 32'(md_ready), 1);
            md_addr = 11; md_data = 32'h200 + i;
            tick();
            md_valid = 0;
            check("wrap_full", 32'(md_ready), 0);
            idle();
            tick();
            check("wrap_a_addr", 32'(RegWrite), 10);
            check("wrap_a_data", WData, 32'h100 + i);
            check("wrap_ready_after", 32'(md_ready), 1);
            tick();
            check("wrap_b_addr", 32'(RegWrite), 11);
            check("wrap_b_data", WData, 32'h200 + i);
            tick();
            check("wrap_drained", 32'(WriteEn), 0);
        end
        check("wrap_err", 32'(err), 0);

        // Contract: double issue of $4.
        iss_valid = 1; iss_addr = 4;
        tick();
        check("iss_once_err", 32'(err), 0);
        tick();
        idle();
        check("iss_twice_err", 32'(err), 1);
        pulse_reset();
        check("err_reset", 32'(err), 0);

        // Contract: result to a non-busy register.
        tick();
        md_valid = 1; md_addr = 6; md_data = 32'h6;
        tick();
        idle();
        check("md_nonbusy_err", 32'(err), 1);
        pulse_reset();

        // Result to $0: accepted, dropped, no error.
        tick();
        md_valid = 1; md_addr = 0; md_data = 32'h99;
        #1;
        check("md0_ready", 32'(md_ready), 1);
        tick();
        idle();
        check("md0_err", 32'(err), 0);
        tick();
        check("md0_nowrite", 32'(WriteEn), 0);

        // Reset mid-operation with two queued entries on $12.
        q_addr1 = 12;
        iss_valid = 1; iss_addr = 12;
        tick();
        idle();
        pipe_we = 1; pipe_addr = 3; pipe_data = 32'h77;
        md_valid = 1; md_addr = 12; md_data = 32'hC1;
        tick();
        md_data = 32'hC2;
        tick();
        idle();
        check("pre_rst_full", 32'(md_ready), 0);
        check("pre_rst_busy", 32'(q_busy1), 1);
        check("pre_rst_we",   32'(WriteEn), 1);
        reset = 0;
        #1;
        check("mid_rst_we",    32'(WriteEn), 0);
        check("mid_rst_addr",  32'(RegWrite), 0);
        check("mid_rst_data",  WData, 0);
        check("mid_rst_ready", 32'(md_ready), 1);
        check("mid_rst_busy",  32'(q_busy1), 0);
        #4;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_nowrite", 32'(WriteEn), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
